// File: rtl/archer_arrow_ctl.sv
// archer_arrow_ctl: turns a rising edge of draw_weapon into one horizontal
// arrow. The arrow moves ARROW_SPEED px per frame_tick, ends its flight on a
// boss hit or at a screen edge, and a cooldown of COOLDOWN_TICKS frames follows.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no arrow; a fresh draw_weapon rising edge launches one
//   FLY      | arrow in flight; hit test every clk, move on frame_tick
//   COOLDOWN | flight over; count frame_ticks before accepting a new launch
module archer_arrow_ctl #(
  parameter int SCREEN_W       = 1024,
  parameter int ARROW_SPEED    = 8,
  parameter int COOLDOWN_TICKS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        draw_weapon_i,
  input  logic        flip_hor_archer_i,
  input  logic [11:0] pos_x_archer_offset_i,
  input  logic [11:0] pos_y_archer_offset_i,
  input  logic [11:0] boss_x_min_i,
  input  logic [11:0] boss_x_max_i,
  input  logic [11:0] boss_y_min_i,
  input  logic [11:0] boss_y_max_i,
  output logic        arrow_active_o,
  output logic [11:0] arrow_x_o,
  output logic [11:0] arrow_y_o,
  output logic        arrow_flip_o,
  output logic        arrow_hit_o,
  output logic        busy_o
);

  localparam int          CNT_W    = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [12:0] X_LIMIT  = 13'(SCREEN_W - 1);
  localparam logic [12:0] SPEED_13 = 13'(ARROW_SPEED);
  localparam logic [11:0] SPEED_12 = 12'(ARROW_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t            state_q;
  logic              draw_prev_q;
  logic [11:0]       arrow_x_q;
  logic [11:0]       arrow_y_q;
  logic              arrow_flip_q;
  logic              arrow_hit_q;
  logic              arrow_active_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cool_cnt_q;

  logic              launch_req;
  logic [12:0]       x_fwd;
  logic              exit_right;
  logic              exit_left;
  logic              in_box;

  // Launch edge detect, next forward position and boundary / hitbox tests on the registered arrow.
  always_comb begin
    launch_req = draw_weapon_i & ~draw_prev_q;
    x_fwd      = {1'b0, arrow_x_q} + SPEED_13;
    exit_right = (x_fwd > X_LIMIT);
    exit_left  = (arrow_x_q < SPEED_12);
    // Inverted bounds make one of the range compares impossible, so they never hit.
    in_box     = (arrow_x_q >= boss_x_min_i) && (arrow_x_q <= boss_x_max_i) &&
                 (arrow_y_q >= boss_y_min_i) && (arrow_y_q <= boss_y_max_i);
  end

  // Arrow FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      draw_prev_q    <= 1'b1;
      arrow_x_q      <= '0;
      arrow_y_q      <= '0;
      arrow_flip_q   <= 1'b0;
      arrow_hit_q    <= 1'b0;
      arrow_active_q <= 1'b0;
      busy_q         <= 1'b0;
      cool_cnt_q     <= '0;
    end else begin
      draw_prev_q <= draw_weapon_i;
      arrow_hit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch_req) begin
            state_q        <= FLY;
            arrow_x_q      <= pos_x_archer_offset_i;
            arrow_y_q      <= pos_y_archer_offset_i;
            arrow_flip_q   <= flip_hor_archer_i;
            arrow_active_q <= 1'b1;
            busy_q         <= 1'b1;
          end
        end
        FLY: begin
          if (in_box) begin
            // A hit wins over a simultaneous frame_tick: the arrow stays where it struck.
            state_q        <= COOLDOWN;
            arrow_hit_q    <= 1'b1;
            arrow_active_q <= 1'b0;
            cool_cnt_q     <= '0;
          end else if (frame_tick_i) begin
            if (!arrow_flip_q) begin
              if (exit_right) begin
                state_q        <= COOLDOWN;
                arrow_active_q <= 1'b0;
                cool_cnt_q     <= '0;
              end else begin
                arrow_x_q <= x_fwd[11:0];
              end
            end else begin
              if (exit_left) begin
                state_q        <= COOLDOWN;
                arrow_active_q <= 1'b0;
                cool_cnt_q     <= '0;
              end else begin
                arrow_x_q <= arrow_x_q - SPEED_12;
              end
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick_i) begin
            if (cool_cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cool_cnt_q <= cool_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q        <= IDLE;
          arrow_active_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign arrow_active_o = arrow_active_q;
  assign arrow_x_o      = arrow_x_q;
  assign arrow_y_o      = arrow_y_q;
  assign arrow_flip_o   = arrow_flip_q;
  assign arrow_hit_o    = arrow_hit_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_archer_arrow_ctl.sv
// Directed bench for archer_arrow_ctl: launch, flight, edge exit, boss hit,
// cooldown length, ignored launches and reset behaviour.
module tb_archer_arrow_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        draw_weapon;
  logic        flip_hor;
  logic [11:0] pos_x, pos_y;
  logic [11:0] bx_min, bx_max, by_min, by_max;
  logic        arrow_active;
  logic [11:0] arrow_x, arrow_y;
  logic        arrow_flip;
  logic        arrow_hit;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  archer_arrow_ctl dut (
    .clk                   (clk),
    .rst                   (rst),
    .frame_tick_i          (frame_tick),
    .draw_weapon_i         (draw_weapon),
    .flip_hor_archer_i     (flip_hor),
    .pos_x_archer_offset_i (pos_x),
    .pos_y_archer_offset_i (pos_y),
    .boss_x_min_i          (bx_min),
    .boss_x_max_i          (bx_max),
    .boss_y_min_i          (by_min),
    .boss_y_max_i          (by_max),
    .arrow_active_o        (arrow_active),
    .arrow_x_o             (arrow_x),
    .arrow_y_o             (arrow_y),
    .arrow_flip_o          (arrow_flip),
    .arrow_hit_o           (arrow_hit),
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int n = 1);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_active"}, {31'd0, arrow_active}, 32'd0);
    chk({tag, "_x"},      {20'd0, arrow_x},      32'd0);
    chk({tag, "_y"},      {20'd0, arrow_y},      32'd0);
    chk({tag, "_flip"},   {31'd0, arrow_flip},   32'd0);
    chk({tag, "_hit"},    {31'd0, arrow_hit},    32'd0);
    chk({tag, "_busy"},   {31'd0, busy},         32'd0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; draw_weapon = 1'b0; flip_hor = 1'b0;
    pos_x = '0; pos_y = '0;
    bx_min = 12'd4000; bx_max = 12'd4095; by_min = 12'd0; by_max = 12'd4095;
    step(2);
    rst = 1'b0;
    chk_reset_vals("rst");

    // 1: launch right from (300,200), 10 ticks to x=380; draw edge mid-flight ignored
    step();
    pos_x = 12'd300; pos_y = 12'd200; flip_hor = 1'b0; draw_weapon = 1'b1;
    step();
    chk("t1_active", {31'd0, arrow_active}, 32'd1);
    chk("t1_x0",     {20'd0, arrow_x},      32'd300);
    chk("t1_y0",     {20'd0, arrow_y},      32'd200);
    chk("t1_busy",   {31'd0, busy},         32'd1);
    frame(5);
    chk("t1_x5", {20'd0, arrow_x}, 32'd340);
    draw_weapon = 1'b0; step();
    pos_x = 12'd777; pos_y = 12'd55; draw_weapon = 1'b1; step();
    chk("t5_fly_relaunch_x", {20'd0, arrow_x}, 32'd340);
    chk("t5_fly_relaunch_y", {20'd0, arrow_y}, 32'd200);
    frame(5);
    chk("t1_x10",    {20'd0, arrow_x},      32'd380);
    chk("t1_active2", {31'd0, arrow_active}, 32'd1);
    draw_weapon = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();

    // 2: spawn at 1010 going right, exits on second tick with no hit
    pos_x = 12'd1010; pos_y = 12'd20; flip_hor = 1'b0; draw_weapon = 1'b1;
    step();
    chk("t2_x0", {20'd0, arrow_x}, 32'd1010);
    frame();
    chk("t2_x1", {20'd0, arrow_x}, 32'd1018);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t2_exit_active", {31'd0, arrow_active}, 32'd0);
    chk("t2_exit_busy",   {31'd0, busy},         32'd1);
    chk("t2_exit_hit",    {31'd0, arrow_hit},    32'd0);
    chk("t2_exit_x",      {20'd0, arrow_x},      32'd1018);
    step();
    chk("t2_nohit", {31'd0, arrow_hit}, 32'd0);
    frame(14);
    chk("t2_cool14_busy", {31'd0, busy}, 32'd1);
    frame();
    chk("t2_cool15_busy", {31'd0, busy}, 32'd0);

    // 3: spawn 100 going left, boss 60..70 x 150..250, hit once x reaches 68
    draw_weapon = 1'b0; step();
    bx_min = 12'd60; bx_max = 12'd70; by_min = 12'd150; by_max = 12'd250;
    pos_x = 12'd100; pos_y = 12'd200; flip_hor = 1'b1; draw_weapon = 1'b1;
    step();
    chk("t3_flip", {31'd0, arrow_flip}, 32'd1);
    frame(3);
    chk("t3_x76", {20'd0, arrow_x}, 32'd76);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t3_x68",       {20'd0, arrow_x},      32'd68);
    chk("t3_prehit",    {31'd0, arrow_hit},    32'd0);
    chk("t3_preactive", {31'd0, arrow_active}, 32'd1);
    step();
    chk("t3_hit",    {31'd0, arrow_hit},    32'd1);
    chk("t3_active", {31'd0, arrow_active}, 32'd0);
    chk("t3_busy",   {31'd0, busy},         32'd1);
    chk("t3_xhold",  {20'd0, arrow_x},      32'd68);
    step();
    chk("t3_hit_1cyc", {31'd0, arrow_hit}, 32'd0);
    // 5: draw edge during cooldown, held high into IDLE -> no launch
    draw_weapon = 1'b0; step(); draw_weapon = 1'b1;
    frame(14);
    chk("t3_cool14_busy",   {31'd0, busy},         32'd1);
    chk("t5_cool_relaunch", {31'd0, arrow_active}, 32'd0);
    frame();
    chk("t3_cool15_busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("t5_held_active", {31'd0, arrow_active}, 32'd0);
    chk("t5_held_busy",   {31'd0, busy},         32'd0);

    // 4: spawn inside the boss box with frame_tick on the hit cycle
    draw_weapon = 1'b0; step();
    pos_x = 12'd65; pos_y = 12'd180; flip_hor = 1'b0; draw_weapon = 1'b1;
    step();
    chk("t4_active", {31'd0, arrow_active}, 32'd1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_hit",    {31'd0, arrow_hit},    32'd1);
    chk("t4_xhold",  {20'd0, arrow_x},      32'd65);
    chk("t4_active0", {31'd0, arrow_active}, 32'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_single_pulse", {31'd0, arrow_hit}, 32'd0);
    chk("t4_xhold2",       {20'd0, arrow_x},   32'd65);

    // inverted bounds never hit
    draw_weapon = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    bx_min = 12'd200; bx_max = 12'd100; by_min = 12'd0; by_max = 12'd4095;
    pos_x = 12'd150; pos_y = 12'd10; flip_hor = 1'b0; draw_weapon = 1'b1;
    step(3);
    chk("inv_nohit",  {31'd0, arrow_hit},    32'd0);
    chk("inv_active", {31'd0, arrow_active}, 32'd1);

    // 6: reset mid-flight at x=500
    draw_weapon = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    bx_min = 12'd4000; bx_max = 12'd4095;
    pos_x = 12'd500; pos_y = 12'd300; flip_hor = 1'b1; draw_weapon = 1'b1;
    step();
    chk("t6_x", {20'd0, arrow_x}, 32'd500);
    rst = 1'b1; step();
    chk_reset_vals("t6");
    // draw held high through reset release -> no launch
    step(); rst = 1'b0;
    step(3);
    chk("t5_rst_held_active", {31'd0, arrow_active}, 32'd0);
    chk("t5_rst_held_busy",   {31'd0, busy},         32'd0);
    draw_weapon = 1'b0; step();
    pos_x = 12'd42; draw_weapon = 1'b1; step();
    chk("t5_fresh_edge_active", {31'd0, arrow_active}, 32'd1);
    chk("t5_fresh_edge_x",      {20'd0, arrow_x},      32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
